// File: rtl/id_ex_alu_issue_if.sv
// id_ex_alu_issue_if: ID capture, forwarding sources and ALU-facing EX outputs of the ID/EX issue stage.
interface id_ex_alu_issue_if #(parameter int XLEN = 32);
  logic            stall, flush, id_valid;
  logic [XLEN-1:0] id_readdata1, id_readdata2, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [1:0]      id_ALUOp;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
  logic [4:0]      exmem_rd;
  logic            exmem_RegWrite;
  logic [XLEN-1:0] exmem_ALUResult;
  logic [4:0]      memwb_rd;
  logic            memwb_RegWrite;
  logic [XLEN-1:0] memwb_WriteData;
  logic [XLEN-1:0] readdata1, ALUSrcResult, ex_store_data;
  logic [3:0]      ALUControlOp;
  logic            ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal;
  logic [4:0]      ex_rd;
  modport master (
    input  stall, flush, id_valid, id_readdata1, id_readdata2, id_imm,
           id_rs1, id_rs2, id_rd, id_ALUOp, id_funct3, id_funct7b5,
           id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_Branch,
           exmem_rd, exmem_RegWrite, exmem_ALUResult,
           memwb_rd, memwb_RegWrite, memwb_WriteData,
    output readdata1, ALUSrcResult, ALUControlOp, ex_store_data,
           ex_valid, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal
  );
  modport slave (
    output stall, flush, id_valid, id_readdata1, id_readdata2, id_imm,
           id_rs1, id_rs2, id_rd, id_ALUOp, id_funct3, id_funct7b5,
           id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_Branch,
           exmem_rd, exmem_RegWrite, exmem_ALUResult,
           memwb_rd, memwb_RegWrite, memwb_WriteData,
    input  readdata1, ALUSrcResult, ALUControlOp, ex_store_data,
           ex_valid, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX stage register with ALU control decode; define ID_EX_FORWARDING_EN for EX/MEM and MEM/WB operand forwarding.
module id_ex_alu_issue #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  id_ex_alu_issue_if.master bus
);
  typedef struct packed {
    logic            valid, illegal, alusrc, regwrite, memread, memwrite, branch;
    logic [3:0]      aluctl;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm;
  } stage_t;
  stage_t          st, nxt;
  logic            f3_ok;
  logic [3:0]      f3_ctl;
  logic [XLEN-1:0] fwd1, fwd2;
  always_comb begin
    f3_ok  = bus.id_funct3 inside {3'b000, 3'b111, 3'b110, 3'b010};
    f3_ctl = bus.id_funct3 == 3'b111 ? 4'b0000 :
             bus.id_funct3 == 3'b110 ? 4'b0001 :
             bus.id_funct3 == 3'b010 ? 4'b0111 :
             (bus.id_ALUOp == 2'b10 && bus.id_funct7b5) ? 4'b0110 : 4'b0010;
    nxt = '0;
    if (bus.id_valid) begin
      nxt.valid    = 1'b1;
      nxt.illegal  = bus.id_ALUOp[1] & ~f3_ok;
      nxt.aluctl   = bus.id_ALUOp == 2'b00 ? 4'b0010 :
                     bus.id_ALUOp == 2'b01 ? 4'b0110 :
                     f3_ok ? f3_ctl : 4'b1111;
      nxt.alusrc   = bus.id_ALUSrc;
      nxt.regwrite = bus.id_RegWrite;
      nxt.memread  = bus.id_MemRead;
      nxt.memwrite = bus.id_MemWrite;
      nxt.branch   = bus.id_Branch;
      nxt.rs1      = bus.id_rs1;
      nxt.rs2      = bus.id_rs2;
      nxt.rd       = bus.id_rd;
      nxt.rd1      = bus.id_readdata1;
      nxt.rd2      = bus.id_readdata2;
      nxt.imm      = bus.id_imm;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= '0;
    else if (bus.flush) st <= '0;
    else if (!bus.stall) st <= nxt;
`ifdef ID_EX_FORWARDING_EN
  function automatic logic hit(input logic we, input logic [4:0] prd, input logic [4:0] rs);
    return we && prd != 5'd0 && prd == rs;
  endfunction
  // EX/MEM is the younger producer, so it shadows MEM/WB
  always_comb begin
    fwd1 = hit(bus.exmem_RegWrite, bus.exmem_rd, st.rs1) ? bus.exmem_ALUResult :
           hit(bus.memwb_RegWrite, bus.memwb_rd, st.rs1) ? bus.memwb_WriteData : st.rd1;
    fwd2 = hit(bus.exmem_RegWrite, bus.exmem_rd, st.rs2) ? bus.exmem_ALUResult :
           hit(bus.memwb_RegWrite, bus.memwb_rd, st.rs2) ? bus.memwb_WriteData : st.rd2;
  end
`else
  logic unused_fwd;
  assign fwd1 = st.rd1;
  assign fwd2 = st.rd2;
  assign unused_fwd = ^{bus.exmem_rd, bus.exmem_RegWrite, bus.exmem_ALUResult,
                        bus.memwb_rd, bus.memwb_RegWrite, bus.memwb_WriteData, st.rs1, st.rs2};
`endif
  assign bus.readdata1     = st.valid ? fwd1 : '0;
  assign bus.ex_store_data = st.valid ? fwd2 : '0;
  assign bus.ALUSrcResult  = !st.valid ? '0 : st.alusrc ? st.imm : fwd2;
  assign bus.ALUControlOp  = st.aluctl;
  assign bus.ex_valid      = st.valid;
  assign bus.ex_rd         = st.rd;
  assign bus.ex_RegWrite   = st.regwrite;
  assign bus.ex_MemRead    = st.memread;
  assign bus.ex_MemWrite   = st.memwrite;
  assign bus.ex_Branch     = st.branch;
  assign bus.ex_illegal    = st.valid & st.illegal;
endmodule
